// File: rtl/seg7_static_decode.sv
// seg7_static_decode
// Watches a scanned, active-low seven-segment bus and recovers the code shown
// on each of six digits. Glitches are filtered by a stability counter. A digit
// that stops being refreshed is blanked after TIMEOUT_CYC cycles.
module seg7_static_decode #(
   parameter int unsigned STABLE_CNT  = 4,
   parameter int unsigned TIMEOUT_CYC = 1000
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic [6:0] seg_in,
   input  logic [5:0] sel_in,
   output logic [4:0] num0,
   output logic [4:0] num1,
   output logic [4:0] num2,
   output logic [4:0] num3,
   output logic [4:0] num4,
   output logic [4:0] num5,
   output logic [5:0] upd,
   output logic       sel_err
);

   localparam int unsigned NDIG       = 6;
   localparam logic [7:0]  CNT_MAX    = 8'(STABLE_CNT);
   localparam logic [19:0] AGE_MAX    = 20'(TIMEOUT_CYC);
   localparam logic [4:0]  CODE_BLANK = 5'd16;
   localparam logic [4:0]  CODE_BAD   = 5'd31;

   // input stage and the pair registered one edge earlier
   logic [6:0]  s_seg_q, s_seg_d;
   logic [5:0]  s_sel_q, s_sel_d;
   logic [6:0]  p_seg_q, p_seg_d;
   logic [5:0]  p_sel_q, p_sel_d;

   logic [7:0]  cnt_q, cnt_d;
   logic [19:0] age_q [NDIG];
   logic [19:0] age_d [NDIG];
   logic [4:0]  num_q [NDIG];
   logic [4:0]  num_d [NDIG];
   logic [5:0]  upd_q, upd_d;
   logic        sel_err_q, sel_err_d;

   logic [5:0]  sel_inv;
   logic        sel_idle;
   logic        sel_valid;
   logic        same_pair;
   logic        accept;
   logic [4:0]  dec_code;

   // Active-low segment pattern to digit code.
   function automatic logic [4:0] decode_seg(input logic [6:0] seg);
      logic [4:0] code;
      case (seg)
         7'h40:   code = 5'd0;
         7'h79:   code = 5'd1;
         7'h24:   code = 5'd2;
         7'h30:   code = 5'd3;
         7'h19:   code = 5'd4;
         7'h12:   code = 5'd5;
         7'h02:   code = 5'd6;
         7'h78:   code = 5'd7;
         7'h00:   code = 5'd8;
         7'h10:   code = 5'd9;
         7'h08:   code = 5'd10;
         7'h03:   code = 5'd11;
         7'h46:   code = 5'd12;
         7'h21:   code = 5'd13;
         7'h06:   code = 5'd14;
         7'h0E:   code = 5'd15;
         7'h7F:   code = CODE_BLANK;
         default: code = CODE_BAD;
      endcase
      return code;
   endfunction

   // next-state: select classification, stability run, accept and ageing
   always_comb begin
      s_seg_d   = seg_in;
      s_sel_d   = sel_in;
      p_seg_d   = s_seg_q;
      p_sel_d   = s_sel_q;

      sel_inv   = ~s_sel_q;
      sel_idle  = (s_sel_q == '1);
      sel_valid = (sel_inv != '0) && ((sel_inv & (sel_inv - 6'd1)) == '0);
      same_pair = (s_seg_q == p_seg_q) && (s_sel_q == p_sel_q);
      sel_err_d = !sel_idle && !sel_valid;

      if (!sel_valid) begin
         cnt_d = '0;
      end else if (same_pair) begin
         cnt_d = (cnt_q >= CNT_MAX) ? CNT_MAX : cnt_q + 8'd1;
      end else begin
         cnt_d = 8'd1;
      end

      // only the rising step into CNT_MAX accepts; a saturated run does not
      accept   = sel_valid && (cnt_q == CNT_MAX - 8'd1) && (cnt_d == CNT_MAX);
      dec_code = decode_seg(s_seg_q);

      // accept is applied after the timeout so it wins on a shared edge
      for (int unsigned i = 0; i < NDIG; i++) begin
         age_d[i] = (age_q[i] == AGE_MAX) ? AGE_MAX : age_q[i] + 20'd1;
         num_d[i] = num_q[i];
         if ((age_q[i] != AGE_MAX) && (age_d[i] == AGE_MAX)) begin
            num_d[i] = CODE_BLANK;
         end
         if (accept && sel_inv[i]) begin
            num_d[i] = dec_code;
            age_d[i] = '0;
         end
         upd_d[i] = (num_d[i] != num_q[i]);
      end
   end

   // state registers with synchronous active-low reset
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         s_seg_q   <= 7'h7F;
         s_sel_q   <= '1;
         p_seg_q   <= 7'h7F;
         p_sel_q   <= '1;
         cnt_q     <= '0;
         upd_q     <= '0;
         sel_err_q <= 1'b0;
         for (int unsigned i = 0; i < NDIG; i++) begin
            age_q[i] <= '0;
            num_q[i] <= CODE_BLANK;
         end
      end else begin
         s_seg_q   <= s_seg_d;
         s_sel_q   <= s_sel_d;
         p_seg_q   <= p_seg_d;
         p_sel_q   <= p_sel_d;
         cnt_q     <= cnt_d;
         upd_q     <= upd_d;
         sel_err_q <= sel_err_d;
         for (int unsigned i = 0; i < NDIG; i++) begin
            age_q[i] <= age_d[i];
            num_q[i] <= num_d[i];
         end
      end
   end

   assign num0    = num_q[0];
   assign num1    = num_q[1];
   assign num2    = num_q[2];
   assign num3    = num_q[3];
   assign num4    = num_q[4];
   assign num5    = num_q[5];
   assign upd     = upd_q;
   assign sel_err = sel_err_q;

endmodule

// File: doc/seg7_static_decode.md
Name: seg7_static_decode

Overview:
- Receive-side counterpart of the static seven-segment encoder.
- Monitors a scanned, active-low seven-segment bus (segment pattern plus one-hot-low digit select) and recovers the 5-bit digit code shown on each of six digits.
- Filters glitches with a stability counter and blanks any digit that stops being refreshed.
- Used as a display-readback checker and as a front end for panel-capture logic.

Parameters:
- STABLE_CNT, 4: consecutive identical valid samples (same select, same pattern) needed to accept a digit; legal range 2..255.
- TIMEOUT_CYC, 1000: cycles without an accepted refresh before a digit is forced to blank (16); legal range >= STABLE_CNT+1, max 2^20-1.

Ports:
- sys_clk  in  1  system clock, all logic on rising edge.
- sys_rst_n  in  1  reset, synchronous, active-low.
- seg_in  in  7  segment pattern, active-low; bit0 = segment a … bit6 = segment g.
- sel_in  in  6  digit select, active-low one-hot; bit i selects digit i.
- num0..num5  out  5 each  decoded code per digit: 0..15 hex, 16 blank, 31 unrecognised pattern.
- upd  out  6  one-cycle pulse; bit i high when num_i changes value.
- sel_err  out  1  one-cycle pulse when the registered sel_in is not all-ones and not exactly one-hot-low.

Behaviour:
- Reset, synchronous and active-low. All outputs and internal state clear on the first rising edge with sys_rst_n=0:
  - num0..num5 = 16
  - upd = 0, sel_err = 0
  - stability counter = 0
  - age counters = 0
  - input registers: seg = 7'h7F, sel = 6'h3F
- Reset asserted mid-run discards any partial stability run. No output change on the edge that releases reset.
- Input stage: seg_in and sel_in are registered once (s_seg, s_sel) every edge.
- Valid select: s_sel has exactly one zero bit. s_sel all-ones means idle; it is not an error and the counter goes to 0.
- Stability counter cnt (8-bit), evaluated each edge from s_seg/s_sel and the previous registered pair:
  - Valid, and equal to the previous pair: cnt = min(cnt+1, STABLE_CNT).
  - Valid but different (digit or pattern change): cnt = 1.
  - Invalid or idle: cnt = 0.
- Accept: on the edge where cnt goes from STABLE_CNT-1 to STABLE_CNT, digit i (the zero bit of s_sel) is written with the decoded s_seg and its age counter clears. Only one accept per run. A saturated cnt does not re-accept.
- Latency: a pair held stable from before edge 1 is registered at edge 1 and accepted at edge STABLE_CNT+1 (edge 5 at the default).
- Decode table, 7-bit active-low value → code:
  - 40→0, 79→1, 24→2, 30→3, 19→4, 12→5, 02→6, 78→7
  - 00→8, 10→9, 08→A, 03→b, 46→C, 21→d, 06→E, 0E→F
  - 7F→16 (blank)
  - any other value → 31
- Age counters: one per digit, increment each edge, saturate at TIMEOUT_CYC, clear on accept. On the edge an age counter reaches TIMEOUT_CYC, num_i is forced to 16. If an accept of the same digit happens on that same edge, the accept wins and the age counter clears.
- upd[i] pulses on the same edge num_i is written (by accept or by timeout), and only if the new value differs from the old one. Multiple upd bits never assert together by accept, but one accept and one timeout on different digits can coincide.
- sel_err pulses on the edge a registered multi-zero select is seen. When it pulses, cnt = 0.

Test Plan:
- Reset hold: drive sys_rst_n=0 for 3 cycles with seg_in=7'h40 and sel_in=6'h3E → num0..5 = 16, upd = 0 throughout and on release.
- Basic accept: hold sel_in=6'h3E, seg_in=7'h30 from before edge 1 → num0 = 3 and upd = 6'b000001 at edge 5 only. A further 20 stable cycles produce no more upd pulses.
- Glitch rejection: sel_in=6'h3B; seg_in=7'h12 for 3 cycles, then 7'h24 for 1 cycle, then 7'h12 for 5 cycles → num2 only becomes 5, and only after the final run reaches 4. num2 is never 2.
- Full scan: cycle digits 0..5 with patterns 00, 10, 08, 03, 7F, 55 (hex), 6 cycles each → num0..5 = 8, 9, 10, 11, 16, 31.
- Select error and timeout (TIMEOUT_CYC=50):
  - sel_in=6'h3C for 1 cycle → sel_err pulses once and no accept occurs.
  - Accept num1 = 7, then stop refreshing → num1 = 16 with upd[1] pulse exactly 50 edges after the accept edge.
- Mid-run reset: assert reset during the 3rd stable cycle of digit 4 → after release num4 = 16. A fresh 4-cycle run is required to accept.
